// File: rtl/rv_if.sv
// rv_if: valid/ready byte channel between the core's MMIO
// block and its peripherals.
interface rv_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport TX (output valid, output data, input ready);
  modport RX (input valid, input data, output ready);
endinterface

// File: rtl/uart_buffered.sv
// uart_buffered: FIFO-buffered UART with configurable framing,
// mid-bit RX sampling and sticky receive error flags.
module uart_buffered #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int TX_DEPTH   = 4,
  parameter int RX_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  rv_if.RX                          send_req,
  rv_if.TX                          recv_rsp,
  input  logic                      serial_in,
  output logic                      serial_out,
  input  logic                      err_clr,
  output logic                      rx_err_frame,
  output logic                      rx_err_parity,
  output logic                      rx_overrun,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic [$clog2(RX_DEPTH):0] rx_count
);
  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(STOP_BITS * CPB + 1);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;

  localparam logic [CW-1:0]  BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0]  STOP_LAST = CW'(STOP_BITS * CPB - 1);
  localparam logic [BW-1:0]  DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [TCW-1:0] TX_FULL   = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL   = RCW'(RX_DEPTH);
  localparam logic           ODD       = (PARITY == 2);
  localparam logic           HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  // ---------------- TX ----------------
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TAW-1:0]       tx_wr;
  logic [TAW-1:0]       tx_rd;
  logic [DATA_BITS-1:0] tx_head;
  logic [DATA_BITS-1:0] tx_shift;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic                 tx_par;
  logic                 tx_push;
  logic                 tx_pop;
  logic                 tx_avail;
  state_t               tx_state;

  assign send_req.ready = (tx_count != TX_FULL);
  assign tx_push  = send_req.valid && send_req.ready;
  assign tx_avail = (tx_count != '0);
  assign tx_head  = tx_mem[tx_rd];
  // Pop on the cycle a new frame starts, so frames chain with no gap.
  assign tx_pop   = tx_avail &&
                    ((tx_state == S_IDLE) ||
                     (tx_state == S_STOP && tx_cnt == STOP_LAST));

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= send_req.data[DATA_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TAW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TAW'(1);
      tx_count <= tx_count + TCW'(tx_push) - TCW'(tx_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      if (tx_pop) begin
        tx_shift <= tx_head;
        tx_par   <= (^tx_head) ^ ODD;
      end
      unique case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_state <= S_START;
            tx_cnt   <= '0;
          end
        end
        S_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + BW'(1);
            if (tx_bit == DATA_LAST)
              tx_state <= HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= S_STOP;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (tx_cnt == STOP_LAST) begin
            tx_cnt   <= '0;
            tx_state <= tx_pop ? S_START : S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      serial_out <= 1'b1;
    end else begin
      unique case (tx_state)
        S_START:  serial_out <= 1'b0;
        S_DATA:   serial_out <= tx_shift[0];
        S_PARITY: serial_out <= tx_par;
        default:  serial_out <= 1'b1;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic [1:0]           rx_sync;
  logic                 rx_s;
  logic                 rx_prev;
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RAW-1:0]       rx_wr;
  logic [RAW-1:0]       rx_rd;
  logic [DATA_BITS-1:0] rx_shift;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic                 rx_pbit;
  logic                 rx_sample;
  logic                 rx_done;
  logic                 par_bad;
  logic                 frame_set;
  logic                 par_set;
  logic                 ovr_set;
  logic                 rx_push;
  logic                 rx_full;
  logic                 rx_wr_en;
  logic                 rx_pop;
  state_t               rx_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], serial_in};
      rx_prev <= rx_sync[1];
    end
  end

  assign rx_s      = rx_sync[1];
  assign rx_sample = (rx_cnt == BIT_LAST);
  assign rx_done   = (rx_state == S_STOP) && rx_sample;
  assign par_bad   = HAS_PAR && (rx_pbit != ((^rx_shift) ^ ODD));
  assign frame_set = rx_done && !rx_s;
  assign par_set   = rx_done && rx_s && par_bad;
  assign rx_push   = rx_done && rx_s && !par_bad;
  assign rx_full   = (rx_count == RX_FULL);
  assign rx_pop    = recv_rsp.valid && recv_rsp.ready;
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign ovr_set   = rx_push && rx_full && !rx_pop;
  assign rx_wr_en  = rx_push && (!rx_full || rx_pop);

  assign recv_rsp.valid = (rx_count != '0);
  assign recv_rsp.data  = 8'(rx_mem[rx_rd]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_pbit  <= 1'b0;
    end else begin
      unique case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (rx_sample) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_bit   <= rx_bit + BW'(1);
            if (rx_bit == DATA_LAST)
              rx_state <= HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (rx_sample) begin
            rx_cnt   <= '0;
            rx_pbit  <= rx_s;
            rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (rx_sample) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr_en) rx_mem[rx_wr] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_wr_en) rx_wr <= rx_wr + RAW'(1);
      if (rx_pop)   rx_rd <= rx_rd + RAW'(1);
      rx_count <= rx_count + RCW'(rx_wr_en) - RCW'(rx_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_err_frame  <= 1'b0;
      rx_err_parity <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_err_frame  <= frame_set | (rx_err_frame  & ~err_clr);
      rx_err_parity <= par_set   | (rx_err_parity & ~err_clr);
      rx_overrun    <= ovr_set   | (rx_overrun    & ~err_clr);
    end
  end
endmodule

// File: tb/tb_uart_buffered.sv
// tb_uart_buffered: randomized loopback/injection bench with a
// queue-based reference model for two framing configurations.
module tb_uart_buffered;
  localparam int CF    = 10_000_000;
  localparam int BR    = 1_000_000;
  localparam int CPB   = CF / BR;
  localparam int FRAME = (1 + 8 + 0 + 1) * CPB;
  localparam int DEPTH = 4;
  localparam int LIM   = 3000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  rv_if s0();
  rv_if r0();
  rv_if s1();
  rv_if r1();

  logic sin0, sout0, sin1, sout1;
  logic loop0, loop1, inj0, inj1, clr0, clr1;
  logic fe0, pe0, ov0, fe1, pe1, ov1;
  logic [2:0] tc0, rc0, tc1, rc1;

  assign sin0 = loop0 ? sout0 : inj0;
  assign sin1 = loop1 ? sout1 : inj1;

  uart_buffered #(
    .CLOCK_FREQ(CF), .BAUD_RATE(BR), .PARITY(0)
  ) u0 (
    .clk(clk), .rst(rst), .send_req(s0), .recv_rsp(r0),
    .serial_in(sin0), .serial_out(sout0), .err_clr(clr0),
    .rx_err_frame(fe0), .rx_err_parity(pe0), .rx_overrun(ov0),
    .tx_count(tc0), .rx_count(rc0)
  );

  uart_buffered #(
    .CLOCK_FREQ(CF), .BAUD_RATE(BR), .PARITY(1)
  ) u1 (
    .clk(clk), .rst(rst), .send_req(s1), .recv_rsp(r1),
    .serial_in(sin1), .serial_out(sout1), .err_clr(clr1),
    .rx_err_frame(fe1), .rx_err_parity(pe1), .rx_overrun(ov1),
    .tx_count(tc1), .rx_count(rc1)
  );

  logic [7:0] rx0_q[$];
  logic [7:0] rx1_q[$];
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int         tx0_starts[$];
  logic [7:0] tx0_chars[$];
  logic       tx0_stop[$];

  always @(negedge clk) begin
    if (r0.valid && r0.ready) rx0_q.push_back(r0.data);
    if (r1.valid && r1.ready) rx1_q.push_back(r1.data);
  end

  // Line-level decoder for u0's serial output (8N1).
  int         dec_s;
  logic [7:0] dec_d;
  always begin
    @(negedge clk);
    if (!sout0 && rst) begin
      dec_s = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        dec_d[k] = sout0;
      end
      repeat (CPB) @(negedge clk);
      tx0_starts.push_back(dec_s);
      tx0_chars.push_back(dec_d);
      tx0_stop.push_back(sout0);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    int t = 0;
    if (sel == 0) begin s0.data = d; s0.valid = 1'b1; end
    else begin s1.data = d; s1.valid = 1'b1; end
    while (((sel == 0) ? s0.ready : s1.ready) == 1'b0 && t < LIM) begin
      tick(1);
      t++;
    end
    if (t >= LIM) check("push_timeout", t, 0);
    tick(1);
    s0.valid = 1'b0;
    s1.valid = 1'b0;
  endtask

  task automatic drive_bit(input int sel, input logic v);
    if (sel == 0) inj0 = v;
    else inj1 = v;
    tick(CPB);
  endtask

  task automatic inject(input int sel, input logic [7:0] d,
                        input logic use_par, input logic pbit,
                        input logic stop);
    drive_bit(sel, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(sel, d[k]);
    if (use_par) drive_bit(sel, pbit);
    drive_bit(sel, stop);
    for (int k = 0; k < 3; k++) drive_bit(sel, 1'b1);
  endtask

  task automatic wait_rx(input int sel, input int n);
    int t = 0;
    while (((sel == 0) ? rx0_q.size() : rx1_q.size()) < n && t < LIM) begin
      tick(1);
      t++;
    end
    if (t >= LIM) check("rx_timeout", t, 0);
  endtask

  task automatic check_rx0(input string tag);
    wait_rx(0, exp0.size());
    tick(5);
    check({tag, "_n"}, rx0_q.size(), exp0.size());
    foreach (exp0[i])
      check(tag, (i < rx0_q.size()) ? int'(rx0_q[i]) : -1, int'(exp0[i]));
    exp0.delete();
    rx0_q.delete();
  endtask

  task automatic check_rx1(input string tag);
    wait_rx(1, exp1.size());
    tick(5);
    check({tag, "_n"}, rx1_q.size(), exp1.size());
    foreach (exp1[i])
      check(tag, (i < rx1_q.size()) ? int'(rx1_q[i]) : -1, int'(exp1[i]));
    exp1.delete();
    rx1_q.delete();
  endtask

  task automatic clear_tx0();
    tx0_starts.delete();
    tx0_chars.delete();
    tx0_stop.delete();
  endtask

  task automatic pulse_clr(input int sel);
    if (sel == 0) clr0 = 1'b1;
    else clr1 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    clr1 = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [4];
    logic [7:0] d;
    logic       bad;
    int         acc, first_low, low_cnt, t, nstore;

    s0.valid = 1'b0; s0.data = '0; r0.ready = 1'b0;
    s1.valid = 1'b0; s1.data = '0; r1.ready = 1'b0;
    loop0 = 1'b1; loop1 = 1'b1; inj0 = 1'b1; inj1 = 1'b1;
    clr0 = 1'b0; clr1 = 1'b0;

    // Reset state
    tick(3);
    check("rst_sout", sout0, 1);
    check("rst_ready", s0.ready, 1);
    check("rst_valid", r0.valid, 0);
    check("rst_flags", {fe0, pe0, ov0}, 0);
    check("rst_tc", tc0, 0);
    check("rst_rc", rc0, 0);
    rst = 1'b1;
    r0.ready = 1'b1;
    r1.ready = 1'b1;
    tick(5);

    // 1. Loopback, back-to-back frames
    vals[0] = 8'h55; vals[1] = 8'hA3; vals[2] = 8'h00; vals[3] = 8'hFF;
    clear_tx0();
    for (int i = 0; i < 4; i++) begin
      exp0.push_back(vals[i]);
      push(0, vals[i]);
    end
    check_rx0("lb");
    tick(20);
    check("lb_frames", tx0_chars.size(), 4);
    for (int i = 0; i < tx0_chars.size() && i < 4; i++) begin
      check("lb_txchar", tx0_chars[i], vals[i]);
      check("lb_stop", tx0_stop[i], 1);
      if (i > 0) check("lb_gap", tx0_starts[i] - tx0_starts[i-1], FRAME);
    end

    // Random loopback with random gaps
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      exp0.push_back(d);
      push(0, d);
      tick($urandom_range(0, 150));
    end
    check_rx0("rnd_lb");
    tick(200);

    // 2. TX backpressure
    acc = 0;
    first_low = -1;
    low_cnt = -1;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      exp0.push_back(d);
      s0.data = d;
      s0.valid = 1'b1;
      t = 0;
      while (!s0.ready && t < LIM) begin
        if (first_low < 0) begin
          first_low = acc;
          low_cnt = tc0;
        end
        tick(1);
        t++;
      end
      if (t >= LIM) check("bp_timeout", t, 0);
      tick(1);
      acc++;
    end
    s0.valid = 1'b0;
    check("bp_accept_before_full", first_low, DEPTH + 1);
    check("bp_tc_full", low_cnt, DEPTH);
    check_rx0("bp");
    tick(200);

    // 3. Even parity on u1
    push(1, 8'h07);
    t = 0;
    @(negedge clk);
    while (sout1 && t < LIM) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIM) check("par_start_timeout", t, 0);
    repeat (CPB / 2 + 9 * CPB) @(negedge clk);
    check("par_bit", sout1, even_par(8'h07));
    exp1.push_back(8'h07);
    check_rx1("par_lb");
    loop1 = 1'b0;
    tick(20);
    inject(1, 8'h07, 1'b1, ~even_par(8'h07), 1'b1);
    tick(2);
    check("par_bad_valid", r1.valid, 0);
    check("par_bad_rxq", rx1_q.size(), 0);
    check("par_flag", pe1, 1);
    check("par_frame_flag", fe1, 0);
    pulse_clr(1);
    check("par_flag_clr", pe1, 0);

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      bad = 1'($urandom_range(0, 1));
      inject(1, d, 1'b1, even_par(d) ^ bad, 1'b1);
      if (!bad) exp1.push_back(d);
      check("rnd_par_flag", pe1, bad);
      pulse_clr(1);
    end
    check_rx1("rnd_par");

    // 4. Framing error on u0
    loop0 = 1'b0;
    tick(20);
    inject(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    tick(2);
    check("frm_rxq", rx0_q.size(), 0);
    check("frm_rc", rc0, 0);
    check("frm_flag", fe0, 1);
    check("frm_par_flag", pe0, 0);
    pulse_clr(0);
    check("frm_flag_clr", fe0, 0);

    // 5. Overrun
    r0.ready = 1'b0;
    nstore = 0;
    for (int v = 1; v <= 5; v++) begin
      inject(0, 8'(v), 1'b0, 1'b0, 1'b1);
      if (nstore < DEPTH) begin
        exp0.push_back(8'(v));
        nstore++;
      end
    end
    tick(2);
    check("ovr_rc", rc0, nstore);
    check("ovr_flag", ov0, 1);
    check("ovr_frame_flag", fe0, 0);
    r0.ready = 1'b1;
    check_rx0("ovr_drain");
    check("ovr_sticky", ov0, 1);
    pulse_clr(0);
    check("ovr_clr", ov0, 0);

    // 6a. Glitch rejection
    inj0 = 1'b0;
    tick(3);
    inj0 = 1'b1;
    tick(4 * CPB);
    check("glitch_rxq", rx0_q.size(), 0);
    check("glitch_flags", {fe0, pe0, ov0}, 0);
    inject(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    exp0.push_back(8'h5A);
    check_rx0("glitch_after");

    // 6b. Reset mid-frame
    loop0 = 1'b1;
    tick(5);
    push(0, 8'hC3);
    push(0, 8'h3C);
    push(0, 8'h11);
    tick(40);
    check("mid_tc", tc0, 2);
    rst = 1'b0;
    #1;
    check("mid_rst_sout", sout0, 1);
    check("mid_rst_tc", tc0, 0);
    check("mid_rst_rc", rc0, 0);
    check("mid_rst_valid", r0.valid, 0);
    tick(3);
    rst = 1'b1;
    tick(150);
    rx0_q.delete();
    clear_tx0();
    push(0, 8'h96);
    exp0.push_back(8'h96);
    check_rx0("post_rst");
    tick(20);
    check("post_rst_frames", tx0_chars.size(), 1);
    if (tx0_chars.size() > 0) begin
      check("post_rst_txchar", tx0_chars[0], 8'h96);
      check("post_rst_stop", tx0_stop[0], 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
